// File: rtl/fb_pkg.sv
// Shared constants and types for the triple-buffered frame-buffer arbiter.
// Holds the bank geometry, reset bank assignment and the bank-base lookup.
package fb_pkg;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 12;
    localparam int FRAME_WORDS = 76800;
    localparam int MEM_ADDR_W  = 18;
    localparam int CNT_W       = 8;

    typedef logic [1:0] bank_t;

    localparam bank_t RST_WR_BANK = 2'd0;
    localparam bank_t RST_RD_BANK = 2'd2;
    localparam bank_t RST_SPARE   = 2'd1;

    localparam logic [MEM_ADDR_W-1:0] BANK_BASE [3] = '{
        MEM_ADDR_W'(0),
        MEM_ADDR_W'(FRAME_WORDS),
        MEM_ADDR_W'(2 * FRAME_WORDS)
    };

    // Bank index 3 never occurs while the bank invariant holds.
    function automatic logic [MEM_ADDR_W-1:0] bank_base(input bank_t bank);
        case (bank)
            2'd0:    return BANK_BASE[0];
            2'd1:    return BANK_BASE[1];
            2'd2:    return BANK_BASE[2];
            default: return '0;
        endcase
    endfunction

    function automatic logic [MEM_ADDR_W-1:0] phys_addr(input bank_t bank,
                                                        input logic [ADDR_W-1:0] addr);
        return bank_base(bank) + MEM_ADDR_W'(addr);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/fb_bank_rotator.sv
// Rotates the write, display and spare banks on frame publish / display take events
// and keeps the dropped / repeated frame counters.
module fb_bank_rotator
    import fb_pkg::*;
(
    input  logic             p_clock,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             frame_done,
    input  logic             rd_frame_start,
    output bank_t            wr_bank,
    output bank_t            rd_bank,
    output logic             ready_valid,
    output logic             rd_bank_valid,
    output logic [CNT_W-1:0] frames_dropped,
    output logic [CNT_W-1:0] frames_repeated
);

    logic             fd_q, wrote_any;
    bank_t            spare;
    logic             fd_rise, publish, take;

    logic             wrote_any_d, ready_valid_d, rd_bank_valid_d;
    bank_t            wr_bank_d, rd_bank_d, spare_d;
    logic [CNT_W-1:0] dropped_d, repeated_d;

    assign fd_rise = frame_done & ~fd_q;
    // A frame boundary with nothing written since the last one publishes nothing.
    assign publish = fd_rise & wrote_any;
    assign take    = rd_frame_start;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        wr_bank_d       = wr_bank;
        rd_bank_d       = rd_bank;
        spare_d         = spare;
        ready_valid_d   = ready_valid;
        rd_bank_valid_d = rd_bank_valid;
        dropped_d       = frames_dropped;
        repeated_d      = frames_repeated;
        wrote_any_d     = fd_rise ? 1'b0 : (wrote_any | wr_en);

        case ({publish, take})
            2'b10: begin
                if (ready_valid) dropped_d = sat_inc(frames_dropped);
                wr_bank_d     = spare;
                spare_d       = wr_bank;
                ready_valid_d = 1'b1;
            end
            2'b01: begin
                if (ready_valid) begin
                    rd_bank_d       = spare;
                    spare_d         = rd_bank;
                    ready_valid_d   = 1'b0;
                    rd_bank_valid_d = 1'b1;
                end else begin
                    repeated_d = sat_inc(frames_repeated);
                end
            end
            2'b11: begin
                // The just-finished frame goes straight to display; any waiting spare is lost.
                if (ready_valid) dropped_d = sat_inc(frames_dropped);
                rd_bank_d       = wr_bank;
                wr_bank_d       = spare;
                spare_d         = rd_bank;
                ready_valid_d   = 1'b0;
                rd_bank_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            fd_q            <= 1'b0;
            wrote_any       <= 1'b0;
            wr_bank         <= RST_WR_BANK;
            rd_bank         <= RST_RD_BANK;
            spare           <= RST_SPARE;
            ready_valid     <= 1'b0;
            rd_bank_valid   <= 1'b0;
            frames_dropped  <= '0;
            frames_repeated <= '0;
        end else begin
            fd_q            <= frame_done;
            wrote_any       <= wrote_any_d;
            wr_bank         <= wr_bank_d;
            rd_bank         <= rd_bank_d;
            spare           <= spare_d;
            ready_valid     <= ready_valid_d;
            rd_bank_valid   <= rd_bank_valid_d;
            frames_dropped  <= dropped_d;
            frames_repeated <= repeated_d;
        end
    end

endmodule

// File: rtl/fb_triple_buffer_arbiter.sv
// Single-port frame-buffer BRAM owner: capture writes always win, display reads are acked
// when the port is free, and three banks rotate so display and capture never collide.
module fb_triple_buffer_arbiter
    import fb_pkg::*;
(
    input  logic                  p_clock,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  frame_done,
    input  logic                  rd_frame_start,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ack,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic [1:0]            wr_bank,
    output logic [1:0]            rd_bank,
    output logic                  ready_valid,
    output logic                  rd_bank_valid,
    output logic [CNT_W-1:0]      frames_dropped,
    output logic [CNT_W-1:0]      frames_repeated
);

    logic [1:0] ack_q;

    fb_bank_rotator u_rotator (
        .p_clock         (p_clock),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .frame_done      (frame_done),
        .rd_frame_start  (rd_frame_start),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank),
        .ready_valid     (ready_valid),
        .rd_bank_valid   (rd_bank_valid),
        .frames_dropped  (frames_dropped),
        .frames_repeated (frames_repeated)
    );

    assign rd_ack = rd_req & ~wr_en;

    // Bank registers are sampled before this edge's rotation, so a same-cycle access hits the old bank.
    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            ack_q         <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b1;
                mem_addr <= phys_addr(wr_bank, wr_addr);
                mem_din  <= wr_data;
            end else if (rd_ack) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= phys_addr(rd_bank, rd_addr);
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            // Stage 0 drives the BRAM, stage 1 sees mem_dout, then the result is captured.
            ack_q         <= {ack_q[0], rd_ack};
            rd_data_valid <= ack_q[1];
            if (ack_q[1]) rd_data <= mem_dout;
        end
    end

endmodule

// File: tb/tb_fb_triple_buffer_arbiter.sv
// Directed scoreboard bench for fb_triple_buffer_arbiter with a behavioural single-port BRAM.
module tb_fb_triple_buffer_arbiter;

    localparam int FW    = 76800;
    localparam int WORDS = 3 * FW;

    logic        p_clock = 1'b0;
    logic        rst_n;
    logic        wr_en, frame_done, rd_frame_start, rd_req;
    logic [16:0] wr_addr, rd_addr;
    logic [11:0] wr_data;
    logic        rd_ack, rd_data_valid, mem_en, mem_we;
    logic [11:0] rd_data, mem_din;
    logic [11:0] mem_dout = '0;
    logic [17:0] mem_addr;
    logic [1:0]  wr_bank, rd_bank;
    logic        ready_valid, rd_bank_valid;
    logic [7:0]  frames_dropped, frames_repeated;

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [11:0] din;
    } mem_exp_t;

    typedef struct {
        logic [11:0] data;
        int          cyc;
    } rd_exp_t;

    mem_exp_t exp_mem[$];
    rd_exp_t  exp_rd[$];
    int       checks   = 0;
    int       failures = 0;
    int       cyc      = 0;

    logic [11:0] bram [WORDS];

    always #5 p_clock = ~p_clock;
    always @(posedge p_clock) cyc++;

    fb_triple_buffer_arbiter dut (
        .p_clock         (p_clock),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_done      (frame_done),
        .rd_frame_start  (rd_frame_start),
        .rd_req          (rd_req),
        .rd_addr         (rd_addr),
        .rd_ack          (rd_ack),
        .rd_data         (rd_data),
        .rd_data_valid   (rd_data_valid),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .wr_bank         (wr_bank),
        .rd_bank         (rd_bank),
        .ready_valid     (ready_valid),
        .rd_bank_valid   (rd_bank_valid),
        .frames_dropped  (frames_dropped),
        .frames_repeated (frames_repeated)
    );

    function automatic logic [11:0] init_val(input int a);
        logic [31:0] v;
        v = a;
        return v[11:0] ^ 12'h5A5;
    endfunction

    initial begin
        for (int i = 0; i < WORDS; i++) bram[i] = init_val(i);
    end

    always @(posedge p_clock) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_din;
            else        mem_dout       <= bram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge p_clock);
        #1;
    endtask

    // Monitor: every BRAM access and every returned pixel must match the next scoreboard entry.
    always @(negedge p_clock) begin
        mem_exp_t m;
        rd_exp_t  r;
        if (rst_n === 1'b1) begin
            if (mem_en) begin
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected_access", {14'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    m = exp_mem.pop_front();
                    check("mem_we", 32'(mem_we), 32'(m.we));
                    check("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.we) check("mem_din", 32'(mem_din), 32'(m.din));
                end
            end
            if (rd_data_valid) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected_valid", 32'(rd_data), 32'hFFFF_FFFF);
                end else begin
                    r = exp_rd.pop_front();
                    check("rd_data", 32'(rd_data), 32'(r.data));
                    check("rd_latency_cycle", 32'(cyc), 32'(r.cyc));
                end
            end
        end
    end

    task automatic do_write(input int bank, input int addr, input logic [11:0] data);
        mem_exp_t m;
        wr_en   = 1'b1;
        wr_addr = 17'(addr);
        wr_data = data;
        m.we = 1'b1; m.addr = 18'(bank * FW + addr); m.din = data;
        exp_mem.push_back(m);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input int bank, input int addr, input logic [11:0] exp_data);
        mem_exp_t m;
        rd_exp_t  r;
        rd_req  = 1'b1;
        rd_addr = 17'(addr);
        #1;
        check("rd_ack_free_port", 32'(rd_ack), 32'd1);
        m.we = 1'b0; m.addr = 18'(bank * FW + addr); m.din = '0;
        exp_mem.push_back(m);
        r.data = exp_data; r.cyc = cyc + 3;
        exp_rd.push_back(r);
        step();
        rd_req = 1'b0;
    endtask

    task automatic publish_frame(input int bank, input int addr, input logic [11:0] data);
        do_write(bank, addr, data);
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        step();
    endtask

    task automatic take_frame();
        rd_frame_start = 1'b1;
        step();
        rd_frame_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
        check({tag, "_rd_ack"}, 32'(rd_ack), 32'd0);
        check({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
        check({tag, "_rd_bank"}, 32'(rd_bank), 32'd2);
        check({tag, "_ready_valid"}, 32'(ready_valid), 32'd0);
        check({tag, "_rd_bank_valid"}, 32'(rd_bank_valid), 32'd0);
        check({tag, "_frames_dropped"}, 32'(frames_dropped), 32'd0);
        check({tag, "_frames_repeated"}, 32'(frames_repeated), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_done = 1'b0; rd_frame_start = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        exp_mem.delete();
        exp_rd.delete();
        step();
        step();
        check_reset_outputs(tag);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        mem_exp_t m;
        rd_exp_t  r;

        // 1: reset, then an empty frame boundary publishes nothing.
        apply_reset("reset");
        frame_done = 1'b1;
        repeat (3) step();
        frame_done = 1'b0;
        step();
        check("empty_frame_wr_bank", 32'(wr_bank), 32'd0);
        check("empty_frame_ready_valid", 32'(ready_valid), 32'd0);
        check("empty_frame_rd_bank", 32'(rd_bank), 32'd2);

        // 2: ten writes into bank 0, publish (held vsync), then take.
        for (int i = 0; i < 10; i++) begin
            do_write(0, i, 12'h100 + 12'(i));
            step();
        end
        frame_done = 1'b1;
        step();
        check("pub1_wr_bank", 32'(wr_bank), 32'd1);
        check("pub1_ready_valid", 32'(ready_valid), 32'd1);
        repeat (2) step();
        frame_done = 1'b0;
        step();
        check("pub1_level_no_repeat_wr_bank", 32'(wr_bank), 32'd1);
        take_frame();
        check("take1_rd_bank", 32'(rd_bank), 32'd0);
        check("take1_wr_bank", 32'(wr_bank), 32'd1);
        check("take1_ready_valid", 32'(ready_valid), 32'd0);
        check("take1_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
        do_read(0, 0, 12'h100);
        do_read(0, 5, 12'h105);
        do_read(0, 9, 12'h109);
        do_read(0, 100, init_val(100));

        // 3: two publishes without a take drop one frame; then a take and a repeat.
        publish_frame(1, 3, 12'hA11);
        check("pub2_wr_bank", 32'(wr_bank), 32'd2);
        publish_frame(2, 3, 12'hB22);
        check("drop_frames_dropped", 32'(frames_dropped), 32'd1);
        check("drop_ready_valid", 32'(ready_valid), 32'd1);
        check("drop_wr_bank", 32'(wr_bank), 32'd1);
        take_frame();
        check("take2_rd_bank", 32'(rd_bank), 32'd2);
        check("take2_frames_repeated", 32'(frames_repeated), 32'd0);
        take_frame();
        check("repeat_frames_repeated", 32'(frames_repeated), 32'd1);
        check("repeat_rd_bank", 32'(rd_bank), 32'd2);
        check("repeat_wr_bank", 32'(wr_bank), 32'd1);
        do_read(2, 3, 12'hB22);

        // 4: publish and take in the same cycle from the reset bank assignment.
        apply_reset("reset2");
        do_write(0, 20, 12'hC33);
        frame_done = 1'b1;
        rd_frame_start = 1'b1;
        step();
        rd_frame_start = 1'b0;
        check("pt_wr_bank", 32'(wr_bank), 32'd1);
        check("pt_rd_bank", 32'(rd_bank), 32'd0);
        check("pt_ready_valid", 32'(ready_valid), 32'd0);
        check("pt_rd_bank_valid", 32'(rd_bank_valid), 32'd1);
        check("pt_frames_dropped", 32'(frames_dropped), 32'd0);
        frame_done = 1'b0;
        step();
        do_read(0, 20, 12'hC33);

        // 5: write and read collide; the write wins and the read goes one cycle later.
        wr_en = 1'b1; wr_addr = 17'd500; wr_data = 12'hD44;
        rd_req = 1'b1; rd_addr = 17'd7;
        #1;
        check("collide_rd_ack_blocked", 32'(rd_ack), 32'd0);
        m.we = 1'b1; m.addr = 18'(FW + 500); m.din = 12'hD44;
        exp_mem.push_back(m);
        step();
        wr_en = 1'b0;
        #1;
        check("collide_rd_ack_next", 32'(rd_ack), 32'd1);
        m.we = 1'b0; m.addr = 18'd7; m.din = '0;
        exp_mem.push_back(m);
        r.data = 12'h107; r.cyc = cyc + 3;
        exp_rd.push_back(r);
        step();
        rd_req = 1'b0;
        repeat (4) step();
        check("idle_mem_en", 32'(mem_en), 32'd0);
        check("idle_mem_addr_hold", 32'(mem_addr), 32'd7);

        // 6: reset with a read in flight, then saturate the drop counter.
        rd_req = 1'b1; rd_addr = 17'd9;
        m.we = 1'b0; m.addr = 18'd9; m.din = '0;
        exp_mem.push_back(m);
        step();
        rd_req = 1'b0;
        @(negedge p_clock);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midread_reset");
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check("post_reset_rd_data_valid", 32'(rd_data_valid), 32'd0);
        for (int i = 0; i < 301; i++) publish_frame(i % 2, i, 12'(i));
        check("sat_frames_dropped", 32'(frames_dropped), 32'd255);
        check("sat_ready_valid", 32'(ready_valid), 32'd1);
        check("sat_wr_bank", 32'(wr_bank), 32'd1);
        check("sat_rd_bank", 32'(rd_bank), 32'd2);

        for (int i = 0; i < 20 && (exp_mem.size() != 0 || exp_rd.size() != 0); i++) step();
        check("drain_mem_queue", 32'(exp_mem.size()), 32'd0);
        check("drain_rd_queue", 32'(exp_rd.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
